// File: rtl/mc_maindec.sv
// Main control decoder for a multicycle MIPS-style datapath.
// Moore FSM: every control output is decoded from the current state alone.
module mc_maindec (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       branch,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = '0;
        pcsrc      = '0;
        aluop      = '0;
        illegal_op = 1'b0;

        unique case (state)
            FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // An opcode that stopped being LW/SW here abandons the access.
                if (op == OP_LW) begin
                    state_next = MEMRD;
                end else if (op == OP_SW) begin
                    state_next = MEMWR;
                end
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                state_next = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-opcode control-word sequences, random instruction
// streams against an opcode-level reference model, and asynchronous reset cases.
module tb_mc_maindec;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = '0;
    logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch;
    logic       iord, memtoreg, regdst, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [15:0] ctl;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mc_maindec dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .pcwrite    (pcwrite),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .branch     (branch),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Control word: {pcwrite,memwrite,irwrite,regwrite,alusrca,branch,iord,
    //                memtoreg,regdst,alusrcb[1:0],pcsrc[1:0],aluop[1:0],illegal_op}
    assign ctl = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
                  memtoreg, regdst, alusrcb, pcsrc, aluop, illegal_op};

    localparam logic [15:0] C_FETCH  = 16'hA020; // pcwrite, irwrite, alusrcb=01
    localparam logic [15:0] C_DECODE = 16'h0060; // alusrcb=11
    localparam logic [15:0] C_ADR    = 16'h0840; // alusrca, alusrcb=10
    localparam logic [15:0] C_MEMRD  = 16'h0200; // iord
    localparam logic [15:0] C_MEMWR  = 16'h4200; // memwrite, iord
    localparam logic [15:0] C_MEMWB  = 16'h1100; // regwrite, memtoreg
    localparam logic [15:0] C_RTEX   = 16'h0804; // alusrca, aluop=10
    localparam logic [15:0] C_RTWB   = 16'h1080; // regwrite, regdst
    localparam logic [15:0] C_BEQ    = 16'h0C0A; // alusrca, branch, pcsrc=01, aluop=01
    localparam logic [15:0] C_ADDIWB = 16'h1000; // regwrite
    localparam logic [15:0] C_JEX    = 16'h8010; // pcwrite, pcsrc=10
    localparam logic [15:0] C_ILL    = 16'h0001; // illegal_op

    typedef struct {
        logic [5:0]        op;
        int unsigned       len;
        logic [4:0][15:0]  exp;
    } vec_t;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: ctl got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: opcode -> the instruction's per-cycle control words.
    function automatic void model(input logic [5:0] o, output int unsigned len,
                                  output logic [4:0][15:0] seq);
        seq = '0;
        seq[0] = C_FETCH;
        seq[1] = C_DECODE;
        case (o)
            6'b100011: begin len = 5; seq[2] = C_ADR;  seq[3] = C_MEMRD; seq[4] = C_MEMWB; end
            6'b101011: begin len = 4; seq[2] = C_ADR;  seq[3] = C_MEMWR; end
            6'b000000: begin len = 4; seq[2] = C_RTEX; seq[3] = C_RTWB; end
            6'b001000: begin len = 4; seq[2] = C_ADR;  seq[3] = C_ADDIWB; end
            6'b000100: begin len = 3; seq[2] = C_BEQ; end
            6'b000010: begin len = 3; seq[2] = C_JEX; end
            default:   begin len = 3; seq[2] = C_ILL; end
        endcase
    endfunction

    // Starts with the DUT in FETCH, 1 ns past an edge; ends in the next FETCH.
    // With jitter, op is garbage except in the DECODE and MEMADR cycles.
    task automatic run_seq(input string nm, input logic [5:0] o, input int unsigned len,
                           input logic [4:0][15:0] exp, input bit jitter);
        for (int unsigned i = 0; i < len; i++) begin
            if (!jitter || i == 1 || i == 2) op = o;
            else op = 6'($urandom);
            check($sformatf("%s[%0d]", nm, i), ctl, exp[i]);
            @(posedge clk);
            #1;
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{op: 6'b100011, len: 5, exp: {C_MEMWB, C_MEMRD, C_ADR, C_DECODE, C_FETCH}};
        tbl[1] = '{op: 6'b101011, len: 4, exp: {16'h0, C_MEMWR, C_ADR, C_DECODE, C_FETCH}};
        tbl[2] = '{op: 6'b000000, len: 4, exp: {16'h0, C_RTWB, C_RTEX, C_DECODE, C_FETCH}};
        tbl[3] = '{op: 6'b001000, len: 4, exp: {16'h0, C_ADDIWB, C_ADR, C_DECODE, C_FETCH}};
        tbl[4] = '{op: 6'b000100, len: 3, exp: {16'h0, 16'h0, C_BEQ, C_DECODE, C_FETCH}};
        tbl[5] = '{op: 6'b000010, len: 3, exp: {16'h0, 16'h0, C_JEX, C_DECODE, C_FETCH}};
        tbl[6] = '{op: 6'b111111, len: 3, exp: {16'h0, 16'h0, C_ILL, C_DECODE, C_FETCH}};
        tbl[7] = '{op: 6'b100010, len: 3, exp: {16'h0, 16'h0, C_ILL, C_DECODE, C_FETCH}};

        // Held in reset across clock edges: FETCH outputs, no writes.
        op = 6'b101011;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", ctl, C_FETCH);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        for (int unsigned t = 0; t < 8; t++) begin
            run_seq($sformatf("tbl_op%b", tbl[t].op), tbl[t].op, tbl[t].len, tbl[t].exp, 1'b0);
        end

        // Asynchronous reset pulse between edges while in MEMRD.
        begin
            int unsigned      len;
            logic [4:0][15:0] seq;
            model(6'b100011, len, seq);
            op = 6'b100011;
            for (int unsigned i = 0; i < 3; i++) begin
                check($sformatf("lw_pre[%0d]", i), ctl, seq[i]);
                @(posedge clk);
                #1;
            end
            check("lw_memrd", ctl, C_MEMRD);
            reset_n = 1'b0;
            #1;
            check("rst_async", ctl, C_FETCH);
            #1;
            reset_n = 1'b1;
            #1;
            check("rst_release", ctl, C_FETCH);
            @(posedge clk);
            #1;
            check("rst_to_decode", ctl, C_DECODE);
            // Finish this instruction from DECODE, then a full one.
            for (int unsigned i = 2; i < len; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("lw_resume[%0d]", i), ctl, seq[i]);
            end
            @(posedge clk);
            #1;
            run_seq("lw_after_rst", 6'b100011, len, seq, 1'b0);
        end

        // Random instruction stream, op scrambled outside DECODE/MEMADR.
        for (int unsigned k = 0; k < 60; k++) begin
            logic [5:0]       o;
            int unsigned      len;
            logic [4:0][15:0] seq;
            case ($urandom_range(0, 6))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b001000;
                4: o = 6'b000100;
                5: o = 6'b000010;
                default: o = 6'($urandom);
            endcase
            model(o, len, seq);
            run_seq($sformatf("rand%0d_op%b", k, o), o, len, seq, 1'b1);
        end
        check("final_fetch", ctl, C_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode field, valid from the cycle after FETCH (instruction register output).
REQ-005 pcwrite  output  1  unconditional PC write enable.
REQ-006 memwrite  output  1  memory write enable.
REQ-007 irwrite  output  1  instruction register write enable.
REQ-008 regwrite  output  1  register file write enable.
REQ-009 alusrca  output  1  ALU A select (0=PC, 1=rs).
REQ-010 branch  output  1  conditional PC write (ANDed with zero outside the block).
REQ-011 iord  output  1  memory address select (0=PC, 1=ALUOut).
REQ-012 memtoreg  output  1  writeback select (0=ALUOut, 1=data register).
REQ-013 regdst  output  1  destination select (0=rt, 1=rd).
REQ-014 alusrcb  output  2  ALU B select (00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2).
REQ-015 pcsrc  output  2  next-PC select (00=ALU result, 01=ALUOut, 10=jump target).
REQ-016 aluop  output  2  ALU operation class to the ALU decoder (00=add, 01=subtract, 10=use funct).
REQ-017 illegal_op  output  1  one-cycle pulse, opcode not supported.

Function
REQ-018 The block SHALL be a Moore FSM; all outputs SHALL be combinational functions of the current state only.
REQ-019 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, ILLEGAL.
REQ-020 Supported opcodes SHALL be LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
REQ-021 FETCH->DECODE unconditionally.
REQ-022 DECODE SHALL branch on op: LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, ADDI->ADDIEX, J->JEX, any other->ILLEGAL.
REQ-023 MEMADR->MEMRD if op=LW, ->MEMWR if op=SW.
REQ-024 MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
REQ-025 MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, ILLEGAL SHALL all go to FETCH.
REQ-026 Any unreachable/undefined state encoding SHALL go to FETCH on the next edge.
REQ-027 Every output not listed for a state SHALL be 0.
REQ-028 FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00, iord=0, alusrca=0, pcsrc=00.
REQ-029 DECODE: alusrca=0, alusrcb=11, aluop=00.
REQ-030 MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
REQ-031 MEMRD: iord=1.  MEMWR: iord=1, memwrite=1.
REQ-032 MEMWB: regwrite=1, memtoreg=1, regdst=0.
REQ-033 RTYPEEX: alusrca=1, alusrcb=00, aluop=10.  RTYPEWB: regwrite=1, regdst=1, memtoreg=0.
REQ-034 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
REQ-035 ADDIWB: regwrite=1, regdst=0, memtoreg=0.
REQ-036 JEX: pcwrite=1, pcsrc=10.
REQ-037 ILLEGAL: illegal_op=1, all other outputs 0 (no architectural state modified).
REQ-038 Latency in cycles from FETCH to next FETCH: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 3.
REQ-039 op changes outside DECODE/MEMADR SHALL not affect state sequencing.

Reset
REQ-040 reset_n low SHALL force state FETCH immediately (asynchronously), independent of clk.
REQ-041 While reset_n is low, outputs SHALL equal FETCH outputs; no memwrite or regwrite SHALL be asserted.
REQ-042 Reset asserted mid-instruction SHALL abandon the instruction; first clk edge after deassertion SHALL move FETCH->DECODE.

Verification
REQ-043 Reset release, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 & memtoreg=1 only in 5th cycle.
REQ-044 op=101011 -> FETCH,DECODE,MEMADR,MEMWR,FETCH; memwrite=1, iord=1 in 4th cycle only.
REQ-045 op=000000 -> aluop=10 in RTYPEEX, regdst=1 & regwrite=1 in RTYPEWB; op=001000 -> aluop=00, alusrcb=10, then regwrite=1 & regdst=0.
REQ-046 op=000100 -> BEQEX with aluop=01, branch=1, pcsrc=01; op=000010 -> JEX with pcwrite=1, pcsrc=10; both back to FETCH after 3 cycles.
REQ-047 op=111111 -> illegal_op=1 for exactly one cycle, no writes, then FETCH.
REQ-048 reset_n pulsed low between edges during MEMRD -> state FETCH before next edge, memwrite/regwrite never asserted, normal sequencing resumes.
